// File: rtl/fp16_mac_tile_sequencer.sv
// fp16_mac_tile_sequencer
//   Control sequencer for one fp16 MAC unit (or a row of MACs sharing control).
//   For every output tile it issues K operand pairs, drains the 2-stage MAC
//   pipeline with zeroed operands, then presents the frozen accumulator value
//   through a valid/ready handshake. Tiles run back-to-back without overlap.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle job request, honoured only in IDLE
//   cfg_k_len/cfg_n_tiles products per tile / tile count, latched on start
//   busy, done, cfg_err   job status; cfg_err pulses with done on a bad config
//   op_req/op_ready       operand pair request and presence (FILL only)
//   op_k, op_tile         index of the requested pair and the current tile
//   op_zero               forces MAC operands to +0 while draining
//   mac_enable            MAC pipeline enable
//   mac_acc_clear         MAC accumulator clear
//   res_valid/res_ready   result handshake, res_tile names the result's tile
module fp16_mac_tile_sequencer #(
  parameter int K_W    = 8,
  parameter int TILE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [K_W-1:0]    cfg_k_len,
  input  logic [TILE_W-1:0] cfg_n_tiles,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              op_req,
  input  logic              op_ready,
  output logic [K_W-1:0]    op_k,
  output logic [TILE_W-1:0] op_tile,
  output logic              op_zero,
  output logic              mac_enable,
  output logic              mac_acc_clear,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [TILE_W-1:0] res_tile
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_DRAIN0 = 3'd2,
    S_DRAIN1 = 3'd3,
    S_RESULT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [K_W-1:0]    K_ZERO = {K_W{1'b0}};
  localparam logic [K_W-1:0]    K_ONE  = {{(K_W-1){1'b0}}, 1'b1};
  localparam logic [TILE_W-1:0] T_ZERO = {TILE_W{1'b0}};
  localparam logic [TILE_W-1:0] T_ONE  = {{(TILE_W-1){1'b0}}, 1'b1};

  state_t              state_r;
  state_t              state_s;
  logic [K_W-1:0]      k_r;
  logic [TILE_W-1:0]   tile_r;
  logic [K_W-1:0]      k_len_r;
  logic [TILE_W-1:0]   n_tiles_r;
  logic                first_pending_r;
  logic                bad_cfg_r;

  logic                accept_s;
  logic                bad_start_s;
  logic                issue_s;
  logic                handshake_s;
  logic                last_k_s;
  logic                last_tile_s;

  // Counters compare against latched length minus one, so the maximum
  // field value never needs a wider counter. Latched values are >= 1
  // whenever these compares are used.
  assign last_k_s    = (k_r == (k_len_r - K_ONE));
  assign last_tile_s = (tile_r == (n_tiles_r - T_ONE));
  assign accept_s    = (state_r == S_IDLE) && start;
  assign bad_start_s = (cfg_k_len == K_ZERO) || (cfg_n_tiles == T_ZERO);
  assign issue_s     = (state_r == S_FILL) && op_ready;
  assign handshake_s = (state_r == S_RESULT) && res_ready;

  assign op_k     = k_r;
  assign op_tile  = tile_r;
  assign res_tile = tile_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_s       = state_r;
    busy          = 1'b0;
    done          = 1'b0;
    cfg_err       = 1'b0;
    op_req        = 1'b0;
    op_zero       = 1'b0;
    mac_enable    = 1'b0;
    res_valid     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = bad_start_s ? S_DONE : S_FILL;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FILL: begin
        busy       = 1'b1;
        op_req     = 1'b1;
        // A stall freezes the whole MAC pipeline, not just the issue.
        mac_enable = op_ready;
        if (op_ready && last_k_s) begin
          state_s = S_DRAIN0;
        end else begin
          state_s = S_FILL;
        end
      end
      S_DRAIN0: begin
        busy       = 1'b1;
        op_zero    = 1'b1;
        mac_enable = 1'b1;
        state_s    = S_DRAIN1;
      end
      S_DRAIN1: begin
        busy       = 1'b1;
        op_zero    = 1'b1;
        mac_enable = 1'b1;
        state_s    = S_RESULT;
      end
      S_RESULT: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) begin
          state_s = last_tile_s ? S_DONE : S_FILL;
        end else begin
          state_s = S_RESULT;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        cfg_err = bad_cfg_r;
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
    // The k=0 product reaches the accumulator input on the next enabled
    // cycle, so the clear rides on that cycle and loads it over any stale
    // value left by the previous tile's drain.
    mac_acc_clear = mac_enable & first_pending_r;
  end

  // Job configuration, latched only on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_len_r   <= K_ZERO;
      n_tiles_r <= T_ZERO;
      bad_cfg_r <= 1'b0;
    end else if (accept_s) begin
      k_len_r   <= cfg_k_len;
      n_tiles_r <= cfg_n_tiles;
      bad_cfg_r <= bad_start_s;
    end
  end

  // Pair index within the tile; wraps to 0 on the last issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_r <= K_ZERO;
    end else if (accept_s) begin
      k_r <= K_ZERO;
    end else if (issue_s) begin
      k_r <= last_k_s ? K_ZERO : (k_r + K_ONE);
    end
  end

  // Tile index; advances on each non-final result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_r <= T_ZERO;
    end else if (accept_s) begin
      tile_r <= T_ZERO;
    end else if (handshake_s && !last_tile_s) begin
      tile_r <= tile_r + T_ONE;
    end
  end

  // Tracks that the k=0 issue happened and the accumulator clear is owed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_pending_r <= 1'b0;
    end else if (mac_acc_clear) begin
      first_pending_r <= 1'b0;
    end else if (issue_s && (k_r == K_ZERO)) begin
      first_pending_r <= 1'b1;
    end
  end

endmodule
